// File: rtl/instr_arb_pkg.sv
// Shared types and default sizes for the instruction RAM arbiter.
package instr_arb_pkg;

  localparam int ADDR_W_DEF   = 12;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 8;

  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DBG} owner_e;
  typedef enum logic       {ST_ARB, ST_LOCK} arb_state_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating stall counter for the debug requester; clear wins over increment.
module arb_wait_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  logic [W-1:0] cnt_q;

  assign at_max_o = (cnt_q == W'(MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !at_max_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/instr_ram_arbiter.sv
// Single-port instruction RAM shared between fetch (F) and debug/loader (D).
// Fixed priority to F, anti-starvation for D, and a lock mode for D bursts.
//
//   state   | meaning
//   ST_ARB  | per-cycle arbitration, F preferred unless D has waited MAX_WAIT
//   ST_LOCK | D owns the port while d_lock stays high; F blocked
module instr_ram_arbiter
  import instr_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic [BE_W-1:0]   d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [BE_W-1:0]   ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta,
  output logic              locked
);

  arb_state_e        state_q;
  owner_e            rsp_owner_q;
  logic [DATA_W-1:0] f_hold_q;
  logic [DATA_W-1:0] d_hold_q;
  logic              at_max;
  logic              in_lock;
  logic              f_win;
  logic              d_win;

  // The cycle that drops d_lock is arbitrated as ARB even though state_q is still LOCK.
  assign in_lock = (state_q == ST_LOCK) && d_lock;

  always_comb begin
    f_win = 1'b0;
    d_win = 1'b0;
    if (rst) begin
      if (in_lock) begin
        d_win = d_req;
      end else if (d_req && (!f_req || at_max)) begin
        d_win = 1'b1;
      end else if (f_req) begin
        f_win = 1'b1;
      end
    end
  end

  always_comb begin
    ram_wea   = '0;
    ram_addra = '0;
    ram_dina  = '0;
    if (d_win) begin
      ram_wea   = d_we;
      ram_addra = d_addr;
      ram_dina  = d_wdata;
    end else if (f_win) begin
      ram_addra = f_addr;
    end
  end

  arb_wait_counter #(.MAX(MAX_WAIT)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (d_req && !d_win),
    .clr_i    (d_win || !d_req),
    .at_max_o (at_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ARB;
      rsp_owner_q <= OWN_NONE;
      f_hold_q    <= '0;
      d_hold_q    <= '0;
      locked      <= 1'b0;
    end else begin
      if (in_lock || (d_win && d_lock)) begin
        state_q <= ST_LOCK;
        locked  <= 1'b1;
      end else begin
        state_q <= ST_ARB;
        locked  <= 1'b0;
      end

      if (f_win)                  rsp_owner_q <= OWN_FETCH;
      else if (d_win && ~|d_we)   rsp_owner_q <= OWN_DBG;
      else                        rsp_owner_q <= OWN_NONE;

      if (rsp_owner_q == OWN_FETCH) f_hold_q <= ram_douta;
      if (rsp_owner_q == OWN_DBG)   d_hold_q <= ram_douta;
    end
  end

  assign f_gnt    = f_win;
  assign d_gnt    = d_win;
  assign f_rvalid = (rsp_owner_q == OWN_FETCH);
  assign d_rvalid = (rsp_owner_q == OWN_DBG);
  assign f_rdata  = f_rvalid ? ram_douta : f_hold_q;
  assign d_rdata  = d_rvalid ? ram_douta : d_hold_q;

endmodule

// File: tb/tb_instr_ram_arbiter.sv
// Directed bench for instr_ram_arbiter with a behavioural RAM and an rdata scoreboard.
module tb_instr_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req;
  logic [11:0] f_addr;
  logic        f_gnt, f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [11:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_lock;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic [3:0]  ram_wea;
  logic [11:0] ram_addra;
  logic [31:0] ram_dina;
  logic [31:0] ram_douta;
  logic        locked;

  int checks = 0;
  int passes = 0;
  logic [31:0] qf[$];
  logic [31:0] qd[$];

  always #5 clk = ~clk;

  instr_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_douta(ram_douta),
    .locked(locked)
  );

  function automatic logic [31:0] initw(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {8'h10, 8'h00, b, b};
  endfunction

  // Behavioural synchronous RAM, filled with initw() on the first clock edge.
  logic [31:0] mem [0:4095];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= initw(i);
      mem_ready <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_wea[b]) mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
    end
    ram_douta <= mem[ram_addra];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (f_rvalid) begin
      if (qf.size() == 0) chk("f_rvalid_unexpected", 32'd1, 32'd0);
      else chk("f_rdata", f_rdata, qf.pop_front());
    end
    if (d_rvalid) begin
      if (qd.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
      else chk("d_rdata", d_rdata, qd.pop_front());
    end
  end

  // One arbitrated cycle: drive, check grants and RAM port, queue expected read data.
  task automatic cyc(input logic fr, input logic [11:0] fa,
                     input logic dr, input logic [3:0] we, input logic [11:0] da,
                     input logic [31:0] wd, input logic lk,
                     input logic efg, input logic edg,
                     input logic [31:0] efd, input logic [31:0] edd);
    @(negedge clk);
    f_req = fr; f_addr = fa;
    d_req = dr; d_we = we; d_addr = da; d_wdata = wd; d_lock = lk;
    #1;
    chk("f_gnt", {31'd0, f_gnt}, {31'd0, efg});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, edg});
    chk("ram_addra", {20'd0, ram_addra}, edg ? {20'd0, da} : (efg ? {20'd0, fa} : 32'd0));
    chk("ram_wea", {28'd0, ram_wea}, edg ? {28'd0, we} : 32'd0);
    if (edg) chk("ram_dina", ram_dina, wd);
    if (efg) qf.push_back(efd);
    if (edg && we == 4'd0) qd.push_back(edd);
  endtask

  task automatic idle();
    cyc(1'b0, 12'd0, 1'b0, 4'd0, 12'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_f_gnt"},    {31'd0, f_gnt},    32'd0);
    chk({tag, "_d_gnt"},    {31'd0, d_gnt},    32'd0);
    chk({tag, "_f_rvalid"}, {31'd0, f_rvalid}, 32'd0);
    chk({tag, "_d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
    chk({tag, "_locked"},   {31'd0, locked},   32'd0);
    chk({tag, "_ram_wea"},  {28'd0, ram_wea},  32'd0);
    chk({tag, "_ram_addr"}, {20'd0, ram_addra}, 32'd0);
    chk({tag, "_f_rdata"},  f_rdata, 32'd0);
    chk({tag, "_d_rdata"},  d_rdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    f_req = 1'b1; f_addr = 12'd9;
    d_req = 1'b0; d_we = 4'd0; d_addr = 12'd0; d_wdata = 32'd0; d_lock = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    f_req = 1'b0;
    rst = 1'b1;

    // F-only stream
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 12'(i), 1'b0, 4'd0, 12'd0, 32'd0, 1'b0, 1'b1, 1'b0, initw(i), 32'd0);
    idle();

    // Contention: F wins 8 cycles, D on the 9th
    for (int k = 0; k < 8; k++)
      cyc(1'b1, 12'd7, 1'b1, 4'd0, 12'h010, 32'd0, 1'b0, 1'b1, 1'b0, initw(7), 32'd0);
    cyc(1'b1, 12'd7, 1'b1, 4'd0, 12'h010, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, initw(16));
    chk("wait_at_max", {28'd0, dut.u_wait.cnt_q}, 32'd8);
    cyc(1'b1, 12'd7, 1'b0, 4'd0, 12'h010, 32'd0, 1'b0, 1'b1, 1'b0, initw(7), 32'd0);
    chk("wait_cleared", {28'd0, dut.u_wait.cnt_q}, 32'd0);
    idle();

    // Byte write then read-back
    cyc(1'b0, 12'd0, 1'b1, 4'b0010, 12'd5, 32'h0000AB00, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    cyc(1'b0, 12'd0, 1'b1, 4'b0000, 12'd5, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h1000AB05);
    idle();

    // Lock acquire (F idle), then 16 locked writes with F requesting
    cyc(1'b0, 12'd0, 1'b1, 4'd0, 12'h020, 32'd0, 1'b1, 1'b0, 1'b1, 32'd0, initw(32));
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 12'd3, 1'b1, 4'hF, 12'(i), 32'hC0DE0000 | i, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
      chk("locked_burst", {31'd0, locked}, 32'd1);
    end
    cyc(1'b1, 12'd3, 1'b0, 4'd0, 12'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'hC0DE0003, 32'd0);
    idle();
    chk("locked_released", {31'd0, locked}, 32'd0);

    // Reset right after a fetch grant: the read response must never appear
    cyc(1'b1, 12'd4, 1'b0, 4'd0, 12'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'hC0DE0004, 32'd0);
    void'(qf.pop_back());
    rst = 1'b0;
    @(negedge clk);
    #1 chk_all_zero("midrst");
    @(negedge clk);
    #1 chk_all_zero("midrst2");
    rst = 1'b1;
    f_req = 1'b0;
    cyc(1'b1, 12'd3, 1'b0, 4'd0, 12'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'hC0DE0003, 32'd0);
    repeat (3) idle();

    chk("qf_drained", qf.size(), 32'd0);
    chk("qd_drained", qd.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
